mem_port_arbiter: RTL and testbench

- Shares one memory port between two requesters: requester 0 is instruction fetch, requester 1 is data load/store.
- Picks the winner with round-robin arbitration and drives `sel` to the 2:1 datapath multiplexers that steer address, write data and write enable onto the port.
- Tracks up to MAX_OUTST in-flight requests in an in-order tag FIFO and routes each memory response back to the requester that issued it.
- Sits between the fetch/memory pipeline stages and the memory subsystem.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_mux2.sv | 15 +
 rtl/mem_port_arbiter_tag_fifo.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter slice.
//   REQ_FETCH / REQ_DATA : requester indices (bit positions in req_valid etc.)
//   arb_state_e          : arbiter FSM states
//   DEF_*                : default widths / depth
//   pick_winner          : round-robin pick between the two requesters
package mem_port_arbiter_pkg;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int unsigned DEF_ADDR_BITS = 32;
  localparam int unsigned DEF_DATA_BITS = 32;
  localparam int unsigned DEF_MAX_OUTST = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // A lone requester always wins; with both asking, the one not granted last.
  function automatic logic pick_winner(input logic [1:0] valid, input logic last_grant);
    if (&valid) return ~last_grant;
    return valid[REQ_DATA];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Generic 2:1 multiplexer used to steer requester fields onto the memory port.
//   sel : 0 selects a, 1 selects b
//   a,b : data inputs, y : selected data
module mux2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each outstanding request.
//   push/tag : enqueue one 1-bit tag (ignored when full)
//   pop      : dequeue the head tag (ignored when empty)
//   head     : tag at the front of the queue
//   count    : number of stored tags; full / empty status flags
module tag_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_OUTST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     tag,
  input  logic                     pop,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned DEPTH_V  = DEPTH;
  localparam logic [PTR_BITS:0] FULL_COUNT = DEPTH_V[PTR_BITS:0];

  logic [DEPTH-1:0]    mem;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= tag;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single memory port.
//   req_valid/req_ready        : per-requester handshake (bit0 fetch, bit1 data)
//   req_addr*/req_wdata*/req_we* : requester fields, steered by sel
//   mem_req_*/mem_addr/mem_wdata/mem_we : memory port request side
//   mem_rsp_valid/mem_rsp_data : in-order responses, one per accepted request
//   rsp_valid/rsp_data         : responses routed back to the issuing requester
//   err_orphan                 : sticky, a response arrived with nothing outstanding
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [ADDR_BITS-1:0] req_addr0,
  input  logic [ADDR_BITS-1:0] req_addr1,
  input  logic [DATA_BITS-1:0] req_wdata0,
  input  logic [DATA_BITS-1:0] req_wdata1,
  input  logic                 req_we0,
  input  logic                 req_we1,
  output logic                 sel,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic                 mem_rsp_valid,
  input  logic [DATA_BITS-1:0] mem_rsp_data,
  output logic [1:0]           rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 err_orphan
);

  localparam int unsigned CNT_BITS = $clog2(MAX_OUTST) + 1;

  arb_state_e          state;
  arb_state_e          state_nxt;
  logic                sel_nxt;
  logic                last_grant;
  logic                last_grant_nxt;
  logic                push;
  logic                pop;
  logic                head;
  logic                full;
  logic                empty;
  logic [CNT_BITS-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Admission uses the registered full flag, so a pop in the same cycle
  // only frees the slot for the following arbitration.
  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    mem_req_valid  = 1'b0;
    req_ready      = '0;
    push           = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if ((|req_valid) && !full) begin
          sel_nxt   = pick_winner(req_valid, last_grant);
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req_valid = req_valid[sel];
        if (req_valid[sel] && mem_req_ready) begin
          req_ready[sel] = 1'b1;
          push           = 1'b1;
          last_grant_nxt = sel;
          state_nxt      = ST_IDLE;
        end else if (!req_valid[sel]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .tag   (sel),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  mux2 #(.WIDTH(ADDR_BITS)) u_addr_mux (
    .sel (sel), .a (req_addr0), .b (req_addr1), .y (mem_addr)
  );
  mux2 #(.WIDTH(DATA_BITS)) u_wdata_mux (
    .sel (sel), .a (req_wdata0), .b (req_wdata1), .y (mem_wdata)
  );
  mux2 #(.WIDTH(1)) u_we_mux (
    .sel (sel), .a (req_we0), .b (req_we1), .y (mem_we)
  );

  assign pop                  = mem_rsp_valid && !empty;
  assign rsp_valid[REQ_FETCH] = pop && (head == REQ_FETCH);
  assign rsp_valid[REQ_DATA]  = pop && (head == REQ_DATA);
  assign rsp_data             = mem_rsp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_orphan <= 1'b0;
    end else if (mem_rsp_valid && (count == '0)) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic        req_we0, req_we1;
  logic        sel;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        err_orphan;

  int checks = 0;
  int failures = 0;

  // Scoreboard: requester tag expected for each outstanding response.
  logic q[$];
  logic lg;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .MAX_OUTST(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_we0(req_we0), .req_we1(req_we1),
    .sel(sel), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_orphan(err_orphan)
  );

  function automatic logic model_win(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  function automatic logic [1:0] onehot(input logic t);
    return t ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    q.delete();
    lg = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Holds the current req_valid pattern and records n accepts into the scoreboard.
  task automatic collect_accepts(input int n, output int got);
    logic t;
    logic [1:0] e;
    got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      @(negedge clk); #1;
      if (req_ready !== 2'b00) begin
        t = model_win(req_valid, lg);
        e = onehot(t);
        checks++;
        if (req_ready !== e) begin
          failures++;
          $display("FAIL accept_grant got=%b want=%b", req_ready, e);
        end
        q.push_back(t);
        lg = t;
        got++;
      end
    end
  endtask

  task automatic drain(input int n, input logic [31:0] base);
    logic t;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 32'(i);
      @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_data = d;
      #1;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL drain_underflow got=%0d want=%0d", 0, 1);
      end else begin
        t = q.pop_front();
        if (rsp_valid !== onehot(t) || rsp_data !== d) begin
          failures++;
          $display("FAIL rsp_route got=%b/%h want=%b/%h", rsp_valid, rsp_data, onehot(t), d);
        end
      end
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    req_addr0 = 32'h100; req_addr1 = 32'h200;
    req_wdata0 = 32'hAAAA_0000; req_wdata1 = 32'hBBBB_1111;
    req_we0 = 1'b1; req_we1 = 1'b0;
    do_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00 || mem_req_valid !== 1'b0 || rsp_valid !== 2'b00 ||
        err_orphan !== 1'b0 || sel !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%b%b%b%b%b want=0000000",
               req_ready, mem_req_valid, rsp_valid, err_orphan, sel);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    int got;
    @(negedge clk);
    req_valid = 2'b01;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL single_idle got=%b/%b want=0/00", mem_req_valid, req_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (sel !== 1'b0 || mem_req_valid !== 1'b1 || mem_addr !== 32'h100 ||
        mem_wdata !== 32'hAAAA_0000 || mem_we !== 1'b1 || req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_issue got=%b/%b/%h/%h/%b/%b want=0/1/100/aaaa0000/1/01",
               sel, mem_req_valid, mem_addr, mem_wdata, mem_we, req_ready);
    end
    q.push_back(1'b0);
    lg = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL single_one_shot got=%b want=00", req_ready);
    end
    drain(1, 32'h55);
    got = 0;
  endtask

  task automatic test_alternate();
    int got;
    int n0, n1;
    do_reset();
    @(negedge clk);
    req_valid = 2'b11;
    mem_req_ready = 1'b1;
    n0 = 0; n1 = 0;
    collect_accepts(4, got);
    foreach (q[i]) if (q[i]) n1++; else n0++;
    checks++;
    if (got != 4 || n0 != 2 || n1 != 2 || q[0] !== 1'b0 || q[1] !== 1'b1) begin
      failures++;
      $display("FAIL alternate got=%0d/%0d/%0d want=4/2/2", got, n0, n1);
    end
    @(negedge clk);
    req_valid = 2'b00;
    drain(4, 32'h1000);
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    req_valid = 2'b10;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      checks++;
      if (sel !== 1'b1 || req_ready !== 2'b00 || mem_req_valid !== 1'b1 || mem_addr !== 32'h200) begin
        failures++;
        $display("FAIL stall_hold got=%b/%b/%b/%h want=1/00/1/200", sel, req_ready, mem_req_valid, mem_addr);
      end
    end
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL stall_release got=%b want=10", req_ready);
    end
    q.push_back(1'b1);
    lg = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 2'b00 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_gap got=%b/%b want=00/0", req_ready, mem_req_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 2'b01 || sel !== 1'b0) begin
      failures++;
      $display("FAIL stall_next_rr got=%b/%b want=01/0", req_ready, sel);
    end
    q.push_back(1'b0);
    lg = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    drain(2, 32'h2000);
  endtask

  task automatic test_full();
    int got;
    do_reset();
    @(negedge clk);
    req_valid = 2'b01;
    mem_req_ready = 1'b1;
    collect_accepts(4, got);
    checks++;
    if (got != 4) begin
      failures++;
      $display("FAIL full_fill got=%0d want=4", got);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 2'b00 || mem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL full_stall got=%b/%b want=00/0", req_ready, mem_req_valid);
      end
    end
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h77;
    #1;
    checks++;
    if (rsp_valid !== onehot(q[0]) || rsp_data !== 32'h77 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL full_pop got=%b/%h/%b want=%b/77/00", rsp_valid, rsp_data, req_ready, onehot(q[0]));
    end
    void'(q.pop_front());
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_same_cycle got=%b want=0", mem_req_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL full_after_pop got=%b want=01", req_ready);
    end
    q.push_back(1'b0);
    lg = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    drain(4, 32'h3000);
  endtask

  task automatic test_order();
    int got;
    logic [1:0] want [3];
    logic [31:0] d;
    do_reset();
    @(negedge clk);
    req_valid = 2'b01;
    mem_req_ready = 1'b1;
    collect_accepts(1, got);
    @(negedge clk);
    req_valid = 2'b10;
    collect_accepts(2, got);
    @(negedge clk);
    req_valid = 2'b00;
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      d = 32'hA + 32'(i);
      @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_data = d;
      #1;
      checks++;
      if (rsp_valid !== want[i] || rsp_data !== d) begin
        failures++;
        $display("FAIL order_%0d got=%b/%h want=%b/%h", i, rsp_valid, rsp_data, want[i], d);
      end
      if (q.size() != 0) void'(q.pop_front());
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_orphan();
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hDEAD;
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL orphan_drop got=%b want=00", rsp_valid);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin
      failures++;
      $display("FAIL orphan_sticky got=%b want=1", err_orphan);
    end
    do_reset();
    #1;
    checks++;
    if (err_orphan !== 1'b0) begin
      failures++;
      $display("FAIL orphan_clear got=%b want=0", err_orphan);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    do_reset();
    @(negedge clk);
    req_valid = 2'b01;
    mem_req_ready = 1'b1;
    collect_accepts(2, got);
    @(negedge clk);
    req_valid = 2'b10;
    mem_req_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (mem_req_valid !== 1'b1 || sel !== 1'b1) begin
      failures++;
      $display("FAIL mid_issue got=%b/%b want=1/1", mem_req_valid, sel);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || req_ready !== 2'b00 || sel !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%b/%b want=0/00/0", mem_req_valid, req_ready, sel);
    end
    req_valid = 2'b00;
    q.delete();
    lg = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL mid_orphan_rsp got=%b want=00", rsp_valid);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin
      failures++;
      $display("FAIL mid_orphan_flag got=%b want=1", err_orphan);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_full();
    test_order();
    test_orphan();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d want=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
